// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: opcodes, flag bit
// positions, FSM encoding and the per-opcode flag update mask.
package alu_issue_ctrl_pkg;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_RED    = 4'b0011;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;
  localparam logic [3:0] OP_LW     = 4'b1000;
  localparam logic [3:0] OP_SW     = 4'b1001;

  // Bit positions inside the packed {z, n, v} flag vector
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Which architectural flags an opcode is allowed to write, as {z, n, v}
  function automatic logic [2:0] flag_upd_mask(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB:                 return 3'b111;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: return 3'b100;
      default:                        return 3'b000;
    endcase
  endfunction

  // Encodings above OP_SW are unassigned
  function automatic logic op_illegal(input logic [3:0] op);
    return op > OP_SW;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_rr_arbiter2.sv
// Two-way round-robin arbiter. Grants only while enabled; the pointer
// remembers the last granted port so a tie goes to the other one.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last;

  // Tie resolves away from the last grant; a lone request always wins
  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = last ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  // Pointer starts at 1 so port 0 takes the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       last <= 1'b1;
    else if (|gnt) last <= gnt[1];
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller sharing one ALU between the execute stage (port 0) and
// the address/debug port (port 1). Registers ALU inputs, captures the
// result, maintains Z/N/V and returns the result over a response handshake.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | arbitrate; accept one request and latch it into alu_*
// ST_EXEC | ALU evaluating; capture result, error and flags at end
// ST_RESP | result held until resp_ready
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter logic FLAG_REQ = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic [3:0]  req0_imm,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  input  logic [3:0]  req1_imm,
  output logic [3:0]  alu_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_imm,
  input  logic [15:0] alu_out,
  input  logic        alu_z,
  input  logic        alu_n,
  input  logic        alu_v,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [15:0] resp_data,
  output logic        resp_err,
  output logic        flag_z,
  output logic        flag_n,
  output logic        flag_v
);

  state_t     state, state_nxt;
  logic [1:0] gnt;
  logic [2:0] flags;
  logic [2:0] upd_mask;

  rr_arbiter2 u_arb (
    .clk (clk),
    .rst (rst),
    .en  (state == ST_IDLE),
    .req ({req1_valid, req0_valid}),
    .gnt (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign resp_valid = (state == ST_RESP);
  assign upd_mask   = flag_upd_mask(alu_op);
  assign flag_z     = flags[FLAG_Z];
  assign flag_n     = flags[FLAG_N];
  assign flag_v     = flags[FLAG_V];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (|gnt) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: if (resp_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Latch granted request on accept; capture result and flags at end of EXEC
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_imm   <= '0;
      resp_id   <= 1'b0;
      resp_data <= '0;
      resp_err  <= 1'b0;
      flags     <= '0;
    end else begin
      if (state == ST_IDLE && |gnt) begin
        alu_op  <= gnt[1] ? req1_op  : req0_op;
        alu_a   <= gnt[1] ? req1_a   : req0_a;
        alu_b   <= gnt[1] ? req1_b   : req0_b;
        alu_imm <= gnt[1] ? req1_imm : req0_imm;
        resp_id <= gnt[1];
      end
      if (state == ST_EXEC) begin
        if (op_illegal(alu_op)) begin
          resp_data <= '0;
          resp_err  <= 1'b1;
        end else begin
          resp_data <= alu_out;
          resp_err  <= 1'b0;
          if (resp_id == FLAG_REQ)
            flags <= (flags & ~upd_mask) | ({alu_z, alu_n, alu_v} & upd_mask);
        end
      end
    end
  end

endmodule
